// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: bundles the hazard controller's decoder/EX/MEM inputs and its
//          pipeline-control outputs into one port.
// Signals:
//   id_valid, id_rs, id_rt, id_uses_rt, id_branch, br_taken  - ID stage view
//   ex_memrd, ex_rd                                          - EX stage view
//   mem_req, mem_ready                                       - MEM stage / data memory
//   pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold,
//   mem_err, stall_cnt                                       - pipeline controls
// Modports: master drives the stage inputs and observes the controls;
//           slave is the controller itself.
interface pipeline_hazard_ctrl_if #(
  parameter int RAW = 4
);
  logic           id_valid;
  logic [RAW-1:0] id_rs;
  logic [RAW-1:0] id_rt;
  logic           id_uses_rt;
  logic           id_branch;
  logic           br_taken;
  logic           ex_memrd;
  logic [RAW-1:0] ex_rd;
  logic           mem_req;
  logic           mem_ready;
  logic           pc_wr;
  logic           ifid_wr;
  logic           ifid_flush;
  logic           idex_bubble;
  logic           pipe_hold;
  logic           mem_err;
  logic [15:0]    stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_branch, br_taken,
           ex_memrd, ex_rd, mem_req, mem_ready,
    input  pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold, mem_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_branch, br_taken,
           ex_memrd, ex_rd, mem_req, mem_ready,
    output pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: hazard sequencer for the 5-stage pipeline. Freezes the pipe while
//          data memory is busy (with timeout), inserts one bubble on a load-use
//          hazard, and flushes IF/ID for BR_PEN cycles on a taken branch/jump.
//          Priority: memory freeze > load-use stall > branch flush.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; also forces all controls low
//   hz     - pipeline_hazard_ctrl_if.slave (stage inputs, control outputs)
// Outputs are Mealy: combinational from state and current inputs.
module pipeline_hazard_ctrl #(
  parameter int RAW    = 4,
  parameter int BR_PEN = 1,
  parameter int MEM_TO = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_hazard_ctrl_if.slave   hz
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [2:0] FCNT_INIT = 3'(BR_PEN - 1);
  localparam logic [7:0] TMO_MAX   = 8'(MEM_TO);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]     state, state_n;
  logic           saved_fl, saved_fl_n;
  logic [2:0]     fcnt, fcnt_n;
  logic [7:0]     tmo, tmo_n;
  logic [15:0]    stall_cnt_r;

  logic [RAW-1:0] rs, rt, rd;
  logic           memfrz, lu, br, act_run, act_flush;
  logic           pc_wr_c, ifid_wr_c, flush_c, bubble_c, hold_c, err_c;

  assign rs = hz.id_rs;
  assign rt = hz.id_rt;
  assign rd = hz.ex_rd;

  assign memfrz = hz.mem_req & ~hz.mem_ready;
  assign lu     = hz.id_valid & hz.ex_memrd &
                  ((rd == rs) | (hz.id_uses_rt & (rd == rt)));
  assign br     = hz.id_valid & hz.id_branch & hz.br_taken;

  // A released MEM_WAIT behaves exactly like the state it interrupted, so a
  // branch or load-use held in ID during the freeze is acted on that cycle.
  assign act_run   = (state == ST_RUN)   | ((state == ST_WAIT) & ~memfrz & ~saved_fl);
  assign act_flush = (state == ST_FLUSH) | ((state == ST_WAIT) & ~memfrz &  saved_fl);

  always_comb begin
    state_n    = state;
    saved_fl_n = saved_fl;
    fcnt_n     = fcnt;
    tmo_n      = tmo;
    pc_wr_c    = 1'b0;
    ifid_wr_c  = 1'b0;
    flush_c    = 1'b0;
    bubble_c   = 1'b0;
    hold_c     = 1'b0;
    err_c      = 1'b0;

    if (act_run) begin
      state_n = ST_RUN;
      if (memfrz) begin
        hold_c     = 1'b1;
        state_n    = ST_WAIT;
        tmo_n      = 8'd1;
        saved_fl_n = 1'b0;
      end else if (lu) begin
        bubble_c = 1'b1;
      end else if (br) begin
        pc_wr_c = 1'b1;
        flush_c = 1'b1;
        if (BR_PEN > 1) begin
          state_n = ST_FLUSH;
          fcnt_n  = FCNT_INIT;
        end
      end else begin
        pc_wr_c   = 1'b1;
        ifid_wr_c = 1'b1;
      end
    end else if (act_flush) begin
      if (memfrz) begin
        // fcnt is left alone so the remaining flush cycles resume afterwards
        hold_c     = 1'b1;
        state_n    = ST_WAIT;
        tmo_n      = 8'd1;
        saved_fl_n = 1'b1;
      end else begin
        pc_wr_c = 1'b1;
        flush_c = 1'b1;
        if (fcnt <= 3'd1) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_FLUSH;
          fcnt_n  = fcnt - 3'd1;
        end
      end
    end else if (state == ST_WAIT) begin
      if (tmo >= TMO_MAX) begin
        // timeout: report and force the pipe to move; any pending flush is dropped
        err_c     = 1'b1;
        pc_wr_c   = 1'b1;
        ifid_wr_c = 1'b1;
        state_n   = ST_RUN;
      end else begin
        hold_c = 1'b1;
        tmo_n  = tmo + 8'd1;
      end
    end else begin
      state_n = ST_RUN;
    end

    // controls read as inactive for as long as reset is asserted
    if (!rst_n) begin
      pc_wr_c   = 1'b0;
      ifid_wr_c = 1'b0;
      flush_c   = 1'b0;
      bubble_c  = 1'b0;
      hold_c    = 1'b0;
      err_c     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      saved_fl    <= 1'b0;
      fcnt        <= 3'd0;
      tmo         <= 8'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      state    <= state_n;
      saved_fl <= saved_fl_n;
      fcnt     <= fcnt_n;
      tmo      <= tmo_n;
      if (!pc_wr_c) stall_cnt_r <= sat_inc16(stall_cnt_r);
    end
  end

  assign hz.pc_wr       = pc_wr_c;
  assign hz.ifid_wr     = ifid_wr_c;
  assign hz.ifid_flush  = flush_c;
  assign hz.idex_bubble = bubble_c;
  assign hz.pipe_hold   = hold_c;
  assign hz.mem_err     = err_c;
  assign hz.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (BR_PEN=2, MEM_TO=15).
// Stimulus sets inputs just after each rising edge and queues the expected
// controls for that cycle; the monitor compares on each falling edge.
// Control vector bit order: {pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_hold, mem_err}.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.RAW(4)) hz ();

  pipeline_hazard_ctrl #(.RAW(4), .BR_PEN(2), .MEM_TO(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  typedef struct {
    string       name;
    logic [5:0]  ctrl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] RUN = 6'b110000;
  localparam logic [5:0] STL = 6'b000100;
  localparam logic [5:0] FL  = 6'b101000;
  localparam logic [5:0] FRZ = 6'b000010;
  localparam logic [5:0] ERR = 6'b110001;
  localparam logic [5:0] RST = 6'b000000;

  // monitor
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = q.pop_front();
      act = {hz.pc_wr, hz.ifid_wr, hz.ifid_flush, hz.idex_bubble, hz.pipe_hold, hz.mem_err};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
      end
      checks++;
      if (hz.stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, hz.stall_cnt, e.cnt);
      end
    end
  end

  task automatic idle();
    hz.id_valid   = 1'b0;
    hz.id_rs      = 4'd0;
    hz.id_rt      = 4'd0;
    hz.id_uses_rt = 1'b0;
    hz.id_branch  = 1'b0;
    hz.br_taken   = 1'b0;
    hz.ex_memrd   = 1'b0;
    hz.ex_rd      = 4'd0;
    hz.mem_req    = 1'b0;
    hz.mem_ready  = 1'b0;
  endtask

  task automatic loaduse(input logic [3:0] rs, input logic [3:0] rt,
                         input logic urt, input logic [3:0] rd);
    hz.id_valid   = 1'b1;
    hz.id_rs      = rs;
    hz.id_rt      = rt;
    hz.id_uses_rt = urt;
    hz.ex_memrd   = 1'b1;
    hz.ex_rd      = rd;
  endtask

  task automatic branch(input logic taken);
    hz.id_valid  = 1'b1;
    hz.id_branch = 1'b1;
    hz.br_taken  = taken;
  endtask

  // queue expectation for the current cycle, then move to the next cycle
  task automatic cyc(input string nm, input logic [5:0] c, input int sc);
    exp_t e;
    e.name = nm;
    e.ctrl = c;
    e.cnt  = 16'(sc);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    loaduse(4'd3, 4'd0, 1'b0, 4'd3);   // hazard present while in reset: must be masked
    hz.mem_req = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", RST, 0);
    rst_n = 1'b1;
    idle();
    cyc("idle", RUN, 0);

    // load-use on rs, then on rt, and two non-hazards
    loaduse(4'd3, 4'd0, 1'b0, 4'd3);  cyc("lu_rs", STL, 0);
    idle();                          cyc("lu_rs_after", RUN, 1);
    loaduse(4'd2, 4'd5, 1'b1, 4'd5);  cyc("lu_rt", STL, 1);
    idle();                          cyc("lu_rt_after", RUN, 2);
    loaduse(4'd2, 4'd5, 1'b0, 4'd5);  cyc("rt_unused", RUN, 2);
    loaduse(4'd3, 4'd0, 1'b0, 4'd3);
    hz.id_valid = 1'b0;              cyc("lu_invalid", RUN, 2);

    // taken branch, BR_PEN=2: two flush cycles; not-taken branch runs
    idle(); branch(1'b1);            cyc("br_flush1", FL, 2);
    idle();                          cyc("br_flush2", FL, 2);
    cyc("br_done", RUN, 2);
    branch(1'b0);                    cyc("br_not_taken", RUN, 2);

    // memory busy for 3 cycles, released on the 4th
    idle(); hz.mem_req = 1'b1;
    cyc("frz1", FRZ, 2);
    cyc("frz2", FRZ, 3);
    cyc("frz3", FRZ, 4);
    hz.mem_ready = 1'b1;             cyc("frz_release", RUN, 5);
    idle();                          cyc("post_frz", RUN, 5);

    // timeout: entry cycle, 14 waits, error pulse on wait with tmo==15
    hz.mem_req = 1'b1;
    cyc("tmo_entry", FRZ, 5);
    for (int i = 0; i < 14; i++) cyc("tmo_wait", FRZ, 6 + i);
    cyc("tmo_err", ERR, 20);
    idle();                          cyc("tmo_run", RUN, 20);

    // freeze with taken branch in ID: no flush until release
    branch(1'b1); hz.mem_req = 1'b1;
    cyc("frzbr1", FRZ, 20);
    cyc("frzbr2", FRZ, 21);
    hz.mem_ready = 1'b1;             cyc("frzbr_release", FL, 22);
    idle();                          cyc("frzbr_flush2", FL, 22);
    cyc("frzbr_done", RUN, 22);

    // freeze arriving mid-flush: flush count held across it
    branch(1'b1);                    cyc("flfrz_flush1", FL, 22);
    idle(); hz.mem_req = 1'b1;       cyc("flfrz_hold", FRZ, 22);
    hz.mem_ready = 1'b1;             cyc("flfrz_flush2", FL, 23);
    idle();                          cyc("flfrz_done", RUN, 23);

    // async reset during MEM_WAIT
    hz.mem_req = 1'b1;
    cyc("rstw_frz1", FRZ, 23);
    cyc("rstw_frz2", FRZ, 24);
    rst_n = 1'b0;                    cyc("rstw_reset", RST, 0);
    rst_n = 1'b1; idle();            cyc("rstw_run", RUN, 0);

    // async reset during FLUSH: pending flush discarded
    branch(1'b1);                    cyc("rstf_flush1", FL, 0);
    idle(); rst_n = 1'b0;            cyc("rstf_reset", RST, 0);
    rst_n = 1'b1;                    cyc("rstf_run", RUN, 0);

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
